// File: rtl/mem_wb_stage.sv
// Memory-access stage and MEM/WB register of the 16-bit pipeline.
// Ports: EX/MEM bundle in, dmem req/ack port, stall out, MEM/WB bundle out.
module mem_wb_stage #(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 3,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              memread_in,
  input  logic              memwrite_in,
  input  logic              memtoreg_in,
  input  logic              regwrite_in,
  input  logic [REG_AW-1:0] write_reg_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] store_data_in,
  input  logic              flush,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic              memtoreg,
  output logic [DATA_W-1:0] rd_data_mem,
  output logic [DATA_W-1:0] rd_data_alu,
  output logic              regwrite,
  output logic [REG_AW-1:0] write_reg,
  output logic              mem_err
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0] state;
  logic [7:0] cnt;
  logic       p_rw;
  logic       p_rd;
  logic       killed;
  logic       mem_op;
  logic       accept;
  logic       tmo;
  logic       kill_now;

  assign mem_op   = memread_in | memwrite_in;
  assign accept   = valid_in & ~flush;
  assign tmo      = (cnt == 8'(TIMEOUT - 1));
  assign kill_now = killed | flush;

  // Upstream may advance on the edge that ends the access
  // (ack or abort), so stall drops in that final cycle.
  always_comb begin
    stall = 1'b0;
    if (rst_n) begin
      if (state == ACCESS)
        stall = ~(dmem_ack | tmo);
      else
        stall = accept & mem_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      p_rw        <= 1'b0;
      p_rd        <= 1'b0;
      killed      <= 1'b0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      wb_valid    <= 1'b0;
      memtoreg    <= 1'b0;
      rd_data_mem <= '0;
      rd_data_alu <= '0;
      regwrite    <= 1'b0;
      write_reg   <= '0;
      mem_err     <= 1'b0;
    end else begin
      mem_err <= 1'b0;
      unique case (state)
        IDLE: begin
          wb_valid <= 1'b0;
          regwrite <= 1'b0;
          if (accept) begin
            memtoreg    <= memtoreg_in;
            write_reg   <= write_reg_in;
            rd_data_alu <= alu_result_in;
            if (mem_op) begin
              dmem_req   <= 1'b1;
              dmem_we    <= memwrite_in;
              dmem_addr  <= alu_result_in;
              dmem_wdata <= store_data_in;
              p_rw       <= regwrite_in;
              p_rd       <= ~memwrite_in;
              killed     <= 1'b0;
              cnt        <= '0;
              state      <= ACCESS;
            end else begin
              wb_valid    <= 1'b1;
              regwrite    <= regwrite_in;
              rd_data_mem <= '0;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt + 8'd1;
          if (flush)
            killed <= 1'b1;
          if (dmem_ack) begin
            dmem_req    <= 1'b0;
            cnt         <= '0;
            state       <= IDLE;
            wb_valid    <= ~kill_now;
            regwrite    <= p_rw & ~kill_now;
            rd_data_mem <= p_rd ? dmem_rdata : '0;
          end else if (tmo) begin
            dmem_req    <= 1'b0;
            cnt         <= '0;
            state       <= IDLE;
            mem_err     <= 1'b1;
            wb_valid    <= 1'b1;
            regwrite    <= 1'b0;
            rd_data_mem <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage.
// Expected MEM/WB records are queued at stimulus time.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in, memread_in, memwrite_in;
  logic        memtoreg_in, regwrite_in;
  logic [2:0]  write_reg_in;
  logic [15:0] alu_result_in, store_data_in;
  logic        flush;
  logic        stall;
  logic        dmem_req, dmem_we;
  logic [15:0] dmem_addr, dmem_wdata;
  logic        dmem_ack;
  logic [15:0] dmem_rdata;
  logic        wb_valid, memtoreg;
  logic [15:0] rd_data_mem, rd_data_alu;
  logic        regwrite;
  logic [2:0]  write_reg;
  logic        mem_err;

  typedef struct packed {
    logic        rw;
    logic [2:0]  wr;
    logic        m2r;
    logic [15:0] mem;
    logic [15:0] alu;
    logic        err;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_wb_stage #(.DATA_W(16), .REG_AW(3), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .memread_in(memread_in),
    .memwrite_in(memwrite_in), .memtoreg_in(memtoreg_in),
    .regwrite_in(regwrite_in), .write_reg_in(write_reg_in),
    .alu_result_in(alu_result_in), .store_data_in(store_data_in),
    .flush(flush), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .memtoreg(memtoreg),
    .rd_data_mem(rd_data_mem), .rd_data_alu(rd_data_alu),
    .regwrite(regwrite), .write_reg(write_reg),
    .mem_err(mem_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (wb_valid) begin
        if (q.size() == 0) begin
          chk("wb_unexp", 32'(wb_valid), 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("wb_rw", 32'(regwrite), 32'(e.rw));
          chk("wb_wr", 32'(write_reg), 32'(e.wr));
          chk("wb_m2r", 32'(memtoreg), 32'(e.m2r));
          chk("wb_mem", 32'(rd_data_mem), 32'(e.mem));
          chk("wb_alu", 32'(rd_data_alu), 32'(e.alu));
          chk("wb_err", 32'(mem_err), 32'(e.err));
        end
      end else begin
        chk("idle_err", 32'(mem_err), 32'd0);
        chk("idle_rw", 32'(regwrite), 32'd0);
      end
    end
  end

  task automatic clr;
    valid_in = 0; memread_in = 0; memwrite_in = 0;
    memtoreg_in = 0; regwrite_in = 0; flush = 0;
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic alu_op(input logic [2:0] wr,
                        input logic [15:0] a,
                        input logic rw,
                        input logic fl);
    valid_in = 1; regwrite_in = rw;
    write_reg_in = wr; alu_result_in = a; flush = fl;
    #1 chk("alu_stall", 32'(stall), 32'd0);
    if (!fl) q.push_back('{rw, wr, 1'b0, 16'h0, a, 1'b0});
    tick(); clr();
  endtask

  // lat: ACCESS cycle carrying ack; kill_at: cycle raising
  // flush (0 = none); lat 0 means never ack (timeout).
  task automatic mem_op(input logic we,
                        input logic [15:0] addr,
                        input logic [15:0] wd,
                        input logic [2:0] wr,
                        input logic rw,
                        input int lat,
                        input int kill_at,
                        input logic [15:0] rd);
    int ncyc;
    valid_in = 1; memread_in = ~we; memwrite_in = we;
    memtoreg_in = ~we; regwrite_in = rw; write_reg_in = wr;
    alu_result_in = addr; store_data_in = wd;
    #1 chk("mem_stall0", 32'(stall), 32'd1);
    tick(); clr();
    ncyc = (lat == 0) ? 15 : lat;
    for (int i = 1; i <= ncyc; i++) begin
      chk("req_hold", 32'(dmem_req), 32'd1);
      chk("we_hold", 32'(dmem_we), 32'(we));
      chk("addr_hold", 32'(dmem_addr), 32'(addr));
      if (we) chk("wd_hold", 32'(dmem_wdata), 32'(wd));
      chk("wb_access", 32'(wb_valid), 32'd0);
      if (i < ncyc) chk("stall_acc", 32'(stall), 32'd1);
      flush = (i == kill_at);
      if (i == lat) begin
        dmem_ack = 1; dmem_rdata = rd;
        #1 chk("stall_ack", 32'(stall), 32'd0);
        if (kill_at == 0)
          q.push_back('{rw, wr, ~we, we ? 16'h0 : rd, addr, 1'b0});
      end else if (lat == 0 && i == ncyc) begin
        q.push_back('{1'b0, wr, 1'b1, 16'h0, addr, 1'b1});
      end
      tick();
      dmem_ack = 0; dmem_rdata = 16'hxxxx; flush = 0;
    end
    chk("req_drop", 32'(dmem_req), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clr();
    write_reg_in = 0; alu_result_in = 0; store_data_in = 0;
    dmem_ack = 0; dmem_rdata = 0;
    rst_n = 0;
    #12;
    chk("rst_wb", 32'(wb_valid), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_alu", 32'(rd_data_alu), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    tick(); rst_n = 1; tick();

    alu_op(3'd5, 16'h1234, 1'b1, 1'b0);
    alu_op(3'd2, 16'hA5A5, 1'b0, 1'b0);
    alu_op(3'd7, 16'hFFFF, 1'b1, 1'b1);
    tick();

    mem_op(1'b0, 16'h0100, 16'h0, 3'd3, 1'b1, 3, 0, 16'hBEEF);
    tick();
    mem_op(1'b1, 16'h0040, 16'h00AA, 3'd0, 1'b0, 1, 0, 16'h5555);
    tick();
    mem_op(1'b0, 16'h0200, 16'h0, 3'd4, 1'b1, 0, 0, 16'h0);
    tick(); tick();
    mem_op(1'b0, 16'h0300, 16'h0, 3'd6, 1'b1, 2, 1, 16'h1111);
    alu_op(3'd1, 16'h0042, 1'b1, 1'b0);
    mem_op(1'b0, 16'h0400, 16'h0, 3'd2, 1'b1, 2, 2, 16'h2222);
    tick();

    valid_in = 1; memread_in = 1; flush = 1;
    #1 chk("flush_idle_stall", 32'(stall), 32'd0);
    tick(); clr();
    chk("flush_idle_req", 32'(dmem_req), 32'd0);

    dmem_ack = 1; dmem_rdata = 16'h9999;
    tick(); dmem_ack = 0;
    chk("idle_ack_wb", 32'(wb_valid), 32'd0);

    valid_in = 1; memread_in = 1; regwrite_in = 1;
    alu_result_in = 16'h0500; write_reg_in = 3'd5;
    tick(); clr(); tick();
    chk("pre_rst_req", 32'(dmem_req), 32'd1);
    rst_n = 0;
    #1;
    chk("rst_mid_req", 32'(dmem_req), 32'd0);
    chk("rst_mid_wb", 32'(wb_valid), 32'd0);
    chk("rst_mid_stall", 32'(stall), 32'd0);
    tick(); rst_n = 1;
    dmem_ack = 1; dmem_rdata = 16'h7777;
    tick(); dmem_ack = 0;
    tick(); tick();
    chk("post_rst_wb", 32'(wb_valid), 32'd0);
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
